// File: rtl/top_model_seq.sv
// top_model_seq -- layer/stage sequencer for a transformer inference run.
//
// A run walks eff = min(num_layer, MAX_LAYER) layers. Each layer has
// NUM_STAGE sub-stages. After the last layer the output head runs.
// The sequencer sends one-cycle kick pulses and waits for the matching
// completion pulse. A per-stage watchdog moves the sequencer to ERR if
// the completion pulse never arrives.
//
// Ports
//   clk          : clock, rising edge
//   rstn         : asynchronous active-low reset
//   start        : run request, accepted only in IDLE or ERR
//   num_layer    : layer count, sampled when start is accepted
//   abort        : synchronous cancel, highest priority
//   stage_done   : per-stage completion pulses; only the active stage is honoured
//   out_done     : output-head completion, honoured only in OUT
//   stage_start  : one-hot one-cycle stage kick
//   out_start    : one-cycle output-head kick
//   done         : one-cycle run-complete pulse
//   busy         : high while in RUN or OUT
//   error        : sticky watchdog flag, cleared by start or abort
//   layer_idx    : current layer
//   stage_idx    : current stage
module top_model_seq #(
  parameter int MAX_LAYER   = 12,
  parameter int NUM_STAGE   = 4,
  parameter int TIMEOUT_CYC = 65535,
  localparam int LW = $clog2(MAX_LAYER + 1),
  localparam int SW = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [LW-1:0]        num_layer,
  input  logic                 abort,
  input  logic [NUM_STAGE-1:0] stage_done,
  input  logic                 out_done,
  output logic [NUM_STAGE-1:0] stage_start,
  output logic                 out_start,
  output logic                 done,
  output logic                 busy,
  output logic                 error,
  output logic [LW-1:0]        layer_idx,
  output logic [SW-1:0]        stage_idx
);

  localparam int WDW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // The counter is 0 in the cycle after a kick. It reaches TIMEOUT_CYC-1
  // one cycle before the limit, so ERR is registered exactly TIMEOUT_CYC
  // cycles after the kick.
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WDW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [LW-1:0]  MAX_L   = LW'(MAX_LAYER);
  localparam logic [SW-1:0]  LAST_S  = SW'(NUM_STAGE - 1);

  typedef enum logic [1:0] {IDLE, RUN, OUT, ERR} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        eff_q, eff_d;
  logic [LW-1:0]        layer_q, layer_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [NUM_STAGE-1:0] stage_start_q, stage_start_d;
  logic                 out_start_q, out_start_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic [LW-1:0]        eff_in;
  logic                 wd_hit;

  assign eff_in = (num_layer > MAX_L) ? MAX_L : num_layer;
  assign wd_hit = (TIMEOUT_CYC != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d       = state_q;
    eff_d         = eff_q;
    layer_d       = layer_q;
    stage_d       = stage_q;
    wd_d          = wd_q;
    err_d         = err_q;
    stage_start_d = '0;
    out_start_d   = 1'b0;
    done_d        = 1'b0;

    if (state_q == RUN || state_q == OUT) wd_d = wd_q + 1'b1;

    if (abort) begin
      state_d = IDLE;
      layer_d = '0;
      stage_d = '0;
      wd_d    = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ERR: begin
          if (start) begin
            eff_d   = eff_in;
            layer_d = '0;
            stage_d = '0;
            wd_d    = '0;
            err_d   = 1'b0;
            if (eff_in == '0) begin
              state_d     = OUT;
              out_start_d = 1'b1;
            end else begin
              state_d          = RUN;
              stage_start_d[0] = 1'b1;
            end
          end
        end
        RUN: begin
          // A completion in the same cycle as the timeout wins.
          if (stage_done[stage_q]) begin
            wd_d = '0;
            if (stage_q != LAST_S) begin
              stage_d       = stage_q + 1'b1;
              stage_start_d = NUM_STAGE'(1) << stage_d;
            end else if (layer_q != eff_q - 1'b1) begin
              layer_d          = layer_q + 1'b1;
              stage_d          = '0;
              stage_start_d[0] = 1'b1;
            end else begin
              // Indices keep their final values while the output head runs.
              state_d     = OUT;
              out_start_d = 1'b1;
            end
          end else if (wd_hit) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        OUT: begin
          if (out_done) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (wd_hit) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      eff_q         <= '0;
      layer_q       <= '0;
      stage_q       <= '0;
      wd_q          <= '0;
      stage_start_q <= '0;
      out_start_q   <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      eff_q         <= eff_d;
      layer_q       <= layer_d;
      stage_q       <= stage_d;
      wd_q          <= wd_d;
      stage_start_q <= stage_start_d;
      out_start_q   <= out_start_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign stage_start = stage_start_q;
  assign out_start   = out_start_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign error       = err_q;
  assign layer_idx   = layer_q;
  assign stage_idx   = stage_q;

endmodule

// File: tb/tb_top_model_seq.sv
// Directed testbench for top_model_seq (MAX_LAYER=12, NUM_STAGE=4, TIMEOUT_CYC=16).
module tb_top_model_seq;

  localparam int LW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [LW-1:0] num_layer;
  logic          abort;
  logic [3:0]    stage_done;
  logic          out_done;
  logic [3:0]    stage_start;
  logic          out_start;
  logic          done;
  logic          busy;
  logic          error;
  logic [LW-1:0] layer_idx;
  logic [SW-1:0] stage_idx;

  int tests = 0;
  int fails = 0;

  top_model_seq #(
    .MAX_LAYER  (12),
    .NUM_STAGE  (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .num_layer  (num_layer),
    .abort      (abort),
    .stage_done (stage_done),
    .out_done   (out_done),
    .stage_start(stage_start),
    .out_start  (out_start),
    .done       (done),
    .busy       (busy),
    .error      (error),
    .layer_idx  (layer_idx),
    .stage_idx  (stage_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {18'd0, stage_start, out_start, done, busy, error, layer_idx, stage_idx};
  endfunction

  // Full run: each stage_done arrives 5 cycles after its kick, and the next kick
  // must follow 1 cycle later. Then out_start, then out_done after 3 cycles.
  task automatic do_run(input int nl, input int exp_layers);
    start = 1'b1; num_layer = LW'(nl);
    tick();
    start = 1'b0;
    chk("run_error_clr", error, 0);
    for (int l = 0; l < exp_layers; l++) begin
      for (int s = 0; s < 4; s++) begin
        chk("kick", stage_start, 32'(1 << s));
        chk("kick_layer", layer_idx, l);
        chk("kick_stage", stage_idx, s);
        chk("kick_busy", busy, 1);
        repeat (4) tick();
        chk("quiet", {out_start, stage_start}, 0);
        stage_done = 4'(1 << s);
        tick();
        stage_done = '0;
      end
    end
    chk("out_start", out_start, 1);
    chk("no_stage_kick", stage_start, 0);
    chk("final_layer", layer_idx, exp_layers - 1);
    chk("final_stage", stage_idx, 3);
    repeat (2) tick();
    chk("no_early_done", done, 0);
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    tick();
    chk("done_pulse_1cyc", done, 0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; num_layer = '0; abort = 1'b0;
    stage_done = '0; out_done = 1'b0;
    #12;
    chk("reset_outputs", all_outs(), 0);
    rstn = 1'b1;
    tick();
    chk("idle_after_reset", all_outs(), 0);

    // Full run, three layers.
    do_run(3, 3);

    // Clamp: 15 layers requested, 12 run.
    do_run(15, 12);

    // Zero layers: straight to the output head.
    start = 1'b1; num_layer = 0;
    tick();
    start = 1'b0;
    chk("zero_out_start", out_start, 1);
    chk("zero_no_stage", stage_start, 0);
    chk("zero_busy", busy, 1);
    tick();
    chk("zero_no_stage2", stage_start, 0);
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    chk("zero_done", done, 1);

    // Wrong and stray dones, then abort on the last stage_done.
    start = 1'b1; num_layer = 1;
    tick();
    start = 1'b0;
    chk("stray_kick0", stage_start, 1);
    tick();
    stage_done = 4'b0100; out_done = 1'b1;
    tick();
    stage_done = '0; out_done = 1'b0;
    chk("stray_no_kick", {done, out_start, stage_start}, 0);
    chk("stray_stage", stage_idx, 0);
    chk("stray_busy", busy, 1);
    for (int s = 0; s < 3; s++) begin
      stage_done = 4'(1 << s);
      tick();
      stage_done = '0;
      chk("stray_adv", stage_start, 32'(1 << (s + 1)));
    end
    stage_done = 4'b1000; abort = 1'b1;
    tick();
    stage_done = '0; abort = 1'b0;
    chk("abort_no_out", {done, out_start, stage_start}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_idx", {layer_idx, stage_idx}, 0);
    tick();
    chk("abort_no_out2", out_start, 0);

    // Abort colliding with start in IDLE.
    abort = 1'b1; start = 1'b1; num_layer = 3;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_idle", {busy, out_start, stage_start}, 0);
    tick();
    chk("abort_start_idle2", {busy, stage_start}, 0);

    // Watchdog: stage 1 never completes.
    start = 1'b1; num_layer = 2;
    tick();
    start = 1'b0;
    stage_done = 4'b0001;
    tick();
    stage_done = '0;
    chk("wd_kick1", stage_start, 2);
    repeat (15) tick();
    chk("wd_not_yet_err", error, 0);
    chk("wd_not_yet_busy", busy, 1);
    tick();
    chk("wd_error", error, 1);
    chk("wd_busy", busy, 0);
    chk("wd_no_done", {done, out_start, stage_start}, 0);
    tick();
    chk("wd_sticky", error, 1);

    // Restart from ERR clears the error; a done at the timeout cycle wins.
    start = 1'b1; num_layer = 1;
    tick();
    start = 1'b0;
    chk("restart_err_clr", error, 0);
    chk("restart_kick", stage_start, 1);
    repeat (15) tick();
    stage_done = 4'b0001;
    tick();
    stage_done = '0;
    chk("race_done_wins", stage_start, 2);
    chk("race_no_err", error, 0);
    chk("race_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("race_abort_idle", busy, 0);

    // Reset during layer 2 (layer_idx 1), then a clean run.
    start = 1'b1; num_layer = 3;
    tick();
    start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      stage_done = 4'(1 << s);
      tick();
      stage_done = '0;
    end
    chk("mid_layer", layer_idx, 1);
    chk("mid_kick", stage_start, 1);
    rstn = 1'b0;
    #1;
    chk("mid_reset_outs", all_outs(), 0);
    tick();
    chk("mid_reset_hold", all_outs(), 0);
    rstn = 1'b1;
    tick();
    do_run(1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/top_model_seq.md
TOP_MODEL_SEQ -- requirements
Module: top_model_seq

Interface
REQ-001 SHALL have parameter MAX_LAYER, default 12, the maximum transformer layers per run (>=1).
REQ-002 SHALL have parameter NUM_STAGE, default 4, the sub-stages per layer (>=1); stage NUM_STAGE-1 is the layer's last stage.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65535, the watchdog limit in cycles per stage; 0 disables the watchdog.
REQ-004 SHALL derive local widths LW = clog2(MAX_LAYER+1) and SW = max(1, clog2(NUM_STAGE)).
REQ-005 SHALL have port clk, input, 1, clock, rising edge.
REQ-006 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, run request.
REQ-008 SHALL have port num_layer, input, LW, layer count for the run, sampled on accepted start.
REQ-009 SHALL have port abort, input, 1, synchronous cancel.
REQ-010 SHALL have port stage_done, input, NUM_STAGE, per-stage completion pulses.
REQ-011 SHALL have port out_done, input, 1, output-head completion.
REQ-012 SHALL have port stage_start, output, NUM_STAGE, one-hot one-cycle kick pulses.
REQ-013 SHALL have port out_start, output, 1, one-cycle output-head kick.
REQ-014 SHALL have port done, output, 1, one-cycle run-complete pulse.
REQ-015 SHALL have port busy, output, 1, high in RUN or OUT.
REQ-016 SHALL have port error, output, 1, sticky watchdog flag.
REQ-017 SHALL have port layer_idx, output, LW, current layer.
REQ-018 SHALL have port stage_idx, output, SW, current stage.

Function
REQ-019 SHALL implement the states IDLE, RUN, OUT and ERR, with every output registered.
REQ-020 SHALL accept start only in IDLE or ERR, and SHALL ignore start in RUN or OUT.
REQ-021 On accepted start SHALL latch eff = min(num_layer, MAX_LAYER), clear error, layer_idx and stage_idx, and the watchdog.
REQ-022 On accepted start, if eff = 0, SHALL go to OUT and pulse out_start on the next cycle.
REQ-023 On accepted start, if eff > 0, SHALL go to RUN and pulse stage_start[0] on the next cycle.
REQ-024 In RUN SHALL honour only stage_done[stage_idx]; other stage_done bits SHALL be ignored.
REQ-025 On an honoured stage_done with stage_idx < NUM_STAGE-1: stage_idx+1, pulse stage_start[stage_idx+1].
REQ-026 On an honoured stage_done with the last stage and layer_idx < eff-1: layer_idx+1, stage_idx 0, pulse stage_start[0].
REQ-027 On an honoured stage_done with the last stage and layer_idx = eff-1: go to OUT and pulse out_start; layer_idx and stage_idx SHALL hold their final values.
REQ-028 Every kick pulse SHALL occur in the cycle after the triggering done; latency SHALL be 1 cycle.
REQ-029 In OUT, out_done SHALL cause IDLE and a done pulse in the next cycle; out_done outside OUT SHALL be ignored.
REQ-030 Watchdog: a counter SHALL clear on every kick pulse and increment each cycle in RUN/OUT.
REQ-031 When the watchdog counter reaches TIMEOUT_CYC (if nonzero) without the awaited done: go to ERR, set error=1, no done pulse.
REQ-032 A done arriving in the same cycle as the timeout SHALL win, and no error SHALL be raised.
REQ-033 abort SHALL force IDLE next cycle from any state: no kicks, no done, layer_idx and stage_idx cleared, error cleared.
REQ-034 abort SHALL take priority over start, stage_done, out_done and timeout in the same cycle.
REQ-035 busy SHALL be 0 in IDLE and ERR.

Reset
REQ-036 rstn low SHALL asynchronously force IDLE and all outputs and internal counters to 0, including mid-run.
REQ-037 The first start after reset release SHALL behave per REQ-021.

Verification
REQ-038 Bench SHALL cover a full run: MAX_LAYER=12, NUM_STAGE=4, num_layer=3, each stage_done 5 cycles after its kick -> 12 stage_start pulses in order 0,1,2,3 x3, then out_start, then done 1 cycle after out_done.
REQ-039 Bench SHALL cover clamp and zero layers: num_layer=15 -> 12 layers run; num_layer=0 -> out_start 1 cycle after start, no stage_start.
REQ-040 Bench SHALL cover wrong and stray dones: stage_done[2] while stage 0 active, and out_done in RUN -> no state change and no pulse.
REQ-041 Bench SHALL cover the watchdog with TIMEOUT_CYC=16 and stage 1 never done -> error=1 and busy=0 exactly 16 cycles after stage_start[1]; start then restarts with error cleared.
REQ-042 Bench SHALL cover abort/start collision: abort with start asserted in IDLE -> remains IDLE; abort with the last stage_done -> no out_start.
REQ-043 Bench SHALL cover reset mid-run: rstn low during layer 2 -> all outputs 0 immediately, and a clean run after release.
